// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI mode-0 slave byte engine with one-entry TX holding register
module spi_slave_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  soft_rst_i,
    input  logic                  enable_i,
    input  logic                  lsb_first_i,
    input  logic                  tx_valid_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  tx_ready_o,
    output logic                  rx_valid_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  underrun_o,
    output logic                  busy_o,
    input  logic                  spi_clk_i,
    input  logic                  spi_cs_n_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        StateIdle,
        StateLoad,
        StateShift,
        StateNext
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_rise;
    logic                   cs_fall;

    state_t                 state;
    logic                   hold_full;
    logic [DATA_WIDTH-1:0]  hold_data;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [DATA_WIDTH-1:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  rx_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   lsb_q;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else if (soft_rst_i) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // A write into an empty register during the load cycle is kept for the next word.
    assign accept = tx_valid_i & ~hold_full;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (soft_rst_i) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= tx_data_i;
        end else if (state == StateLoad) begin
            hold_full <= 1'b0;
        end
    end

    assign rx_next = lsb_q ? {mosi_s, rx_shift[DATA_WIDTH-1:1]}
                           : {rx_shift[DATA_WIDTH-2:0], mosi_s};

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state      <= StateIdle;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            lsb_q      <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
        end else if (soft_rst_i) begin
            state      <= StateIdle;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            lsb_q      <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            if (cs_rise || !enable_i) begin
                state <= StateIdle;
            end else begin
                case (state)
                    StateIdle: begin
                        if (cs_fall) state <= StateLoad;
                    end
                    StateLoad: begin
                        tx_shift <= hold_full ? hold_data : '1;
                        lsb_q    <= lsb_first_i;
                        bit_cnt  <= '0;
                        state    <= StateShift;
                    end
                    StateShift: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_next;
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                                rx_data_o  <= rx_next;
                                rx_valid_o <= 1'b1;
                                state      <= StateNext;
                            end
                        end else if (sclk_fall && bit_cnt != '0) begin
                            tx_shift <= lsb_q ? (tx_shift >> 1) : (tx_shift << 1);
                        end
                    end
                    StateNext: begin
                        if (sclk_fall) state <= StateLoad;
                    end
                    default: state <= StateIdle;
                endcase
            end
        end
    end

    assign tx_ready_o    = ~hold_full;
    assign underrun_o    = (state == StateLoad) & ~hold_full;
    assign busy_o        = (state != StateIdle);
    assign spi_miso_oe_o = (state != StateIdle);
    assign spi_miso_o    = spi_miso_oe_o & (lsb_q ? tx_shift[0] : tx_shift[DATA_WIDTH-1]);

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - directed bench for spi_slave_ctrl driving a mode-0 SPI master model
module tb_spi_slave_ctrl;

    localparam int HALF = 8;

    logic       clk;
    logic       arst;
    logic       soft_rst;
    logic       enable;
    logic       lsb_first;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       underrun;
    logic       busy;
    logic       spi_clk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;

    int         checks;
    int         errors;
    int         rx_cnt;
    int         und_cnt;
    logic [7:0] rx_q[$];

    spi_slave_ctrl #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_i         (clk),
        .arst_i        (arst),
        .soft_rst_i    (soft_rst),
        .enable_i      (enable),
        .lsb_first_i   (lsb_first),
        .tx_valid_i    (tx_valid),
        .tx_data_i     (tx_data),
        .tx_ready_o    (tx_ready),
        .rx_valid_o    (rx_valid),
        .rx_data_o     (rx_data),
        .underrun_o    (underrun),
        .busy_o        (busy),
        .spi_clk_i     (spi_clk),
        .spi_cs_n_i    (spi_cs_n),
        .spi_mosi_i    (spi_mosi),
        .spi_miso_o    (spi_miso),
        .spi_miso_oe_o (spi_miso_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt = rx_cnt + 1;
            rx_q.push_back(rx_data);
        end
        if (underrun) und_cnt = und_cnt + 1;
    end

    typedef struct {
        logic       lsb;
        logic       pre_en;
        logic [7:0] pre;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_und;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input logic lsb, input int nbits,
                            input bit end_frame, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = lsb ? i : 7 - i;
            spi_mosi = tx[b];
            wait_cyc(HALF);
            rx[b]   = spi_miso;
            spi_clk = 1'b1;
            wait_cyc(HALF);
            if (end_frame && i == nbits - 1) spi_cs_n = 1'b1;
            spi_clk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic lsb, input logic pre_en, input logic [7:0] pre,
                             input logic [7:0] mosi, output logic [7:0] rx);
        if (pre_en) push(pre);
        lsb_first = lsb;
        spi_cs_n  = 1'b0;
        wait_cyc(HALF);
        spi_xfer(mosi, lsb, 8, 1'b1, rx);
        wait_cyc(HALF);
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] r2;
        int         rx0;
        int         u0;

        checks    = 0;
        errors    = 0;
        rx_cnt    = 0;
        und_cnt   = 0;
        arst      = 1'b1;
        soft_rst  = 1'b0;
        enable    = 1'b1;
        lsb_first = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        spi_clk   = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;

        vecs[0] = '{lsb: 1'b0, pre_en: 1'b1, pre: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C, exp_und: 0};
        vecs[1] = '{lsb: 1'b1, pre_en: 1'b1, pre: 8'h01, mosi: 8'h80, exp_miso: 8'h01, exp_rx: 8'h80, exp_und: 0};
        vecs[2] = '{lsb: 1'b0, pre_en: 1'b0, pre: 8'h00, mosi: 8'h55, exp_miso: 8'hFF, exp_rx: 8'h55, exp_und: 1};
        vecs[3] = '{lsb: 1'b1, pre_en: 1'b1, pre: 8'hC3, mosi: 8'h0F, exp_miso: 8'hC3, exp_rx: 8'h0F, exp_und: 0};

        wait_cyc(3);
        arst = 1'b0;
        wait_cyc(2);
        check("reset tx_ready", tx_ready, 1);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        check("reset underrun", underrun, 0);
        check("reset busy", busy, 0);
        check("reset miso", spi_miso, 0);
        check("reset miso_oe", spi_miso_oe, 0);

        push(8'h5A);
        check("hold full ready", tx_ready, 0);
        soft_rst = 1'b1;
        wait_cyc(1);
        soft_rst = 1'b0;
        check("soft reset ready", tx_ready, 1);

        for (int v = 0; v < 4; v++) begin
            rx0 = rx_cnt;
            u0  = und_cnt;
            run_frame(vecs[v].lsb, vecs[v].pre_en, vecs[v].pre, vecs[v].mosi, r);
            check($sformatf("vec%0d miso word", v), r, vecs[v].exp_miso);
            check($sformatf("vec%0d rx pulses", v), rx_cnt - rx0, 1);
            check($sformatf("vec%0d rx_data", v), rx_data, vecs[v].exp_rx);
            check($sformatf("vec%0d underruns", v), und_cnt - u0, vecs[v].exp_und);
            check($sformatf("vec%0d tx_ready", v), tx_ready, 1);
            check($sformatf("vec%0d busy", v), busy, 0);
            check($sformatf("vec%0d miso_oe", v), spi_miso_oe, 0);
        end

        rx0 = rx_cnt;
        u0  = und_cnt;
        push(8'h11);
        lsb_first = 1'b0;
        spi_cs_n  = 1'b0;
        wait_cyc(HALF);
        check("two-word ready after load", tx_ready, 1);
        check("two-word busy", busy, 1);
        push(8'h22);
        spi_xfer(8'hAA, 1'b0, 8, 1'b0, r);
        spi_xfer(8'hBB, 1'b0, 8, 1'b1, r2);
        wait_cyc(HALF);
        check("two-word miso 1", r, 8'h11);
        check("two-word miso 2", r2, 8'h22);
        check("two-word rx pulses", rx_cnt - rx0, 2);
        if (rx_cnt - rx0 == 2) begin
            check("two-word rx 1", rx_q[rx0], 8'hAA);
            check("two-word rx 2", rx_q[rx0 + 1], 8'hBB);
        end
        check("two-word underruns", und_cnt - u0, 0);

        rx0 = rx_cnt;
        u0  = und_cnt;
        spi_cs_n = 1'b0;
        wait_cyc(HALF);
        spi_xfer(8'hF0, 1'b0, 2, 1'b0, r);
        wait_cyc(HALF);
        spi_cs_n = 1'b1;
        wait_cyc(HALF);
        check("abort rx pulses", rx_cnt - rx0, 0);
        check("abort busy", busy, 0);
        check("abort miso_oe", spi_miso_oe, 0);
        check("abort underruns", und_cnt - u0, 1);
        rx0 = rx_cnt;
        run_frame(1'b0, 1'b1, 8'h96, 8'h69, r);
        check("post-abort miso", r, 8'h96);
        check("post-abort rx pulses", rx_cnt - rx0, 1);
        check("post-abort rx_data", rx_data, 8'h69);

        rx0 = rx_cnt;
        push(8'h77);
        lsb_first = 1'b0;
        spi_cs_n  = 1'b0;
        wait_cyc(HALF);
        push(8'h12);
        spi_xfer(8'hC3, 1'b0, 4, 1'b0, r);
        check("pre-reset partial miso", r, 8'h70);
        spi_mosi = 1'b0;
        wait_cyc(HALF);
        spi_clk = 1'b1;
        wait_cyc(3);
        #3 arst = 1'b1;
        #1;
        check("arst tx_ready", tx_ready, 1);
        check("arst rx_valid", rx_valid, 0);
        check("arst rx_data", rx_data, 0);
        check("arst underrun", underrun, 0);
        check("arst busy", busy, 0);
        check("arst miso", spi_miso, 0);
        check("arst miso_oe", spi_miso_oe, 0);
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        wait_cyc(2);
        arst = 1'b0;
        wait_cyc(HALF);
        check("post-arst rx pulses", rx_cnt - rx0, 0);
        check("post-arst busy", busy, 0);
        u0 = und_cnt;
        run_frame(1'b0, 1'b0, 8'h00, 8'h5A, r);
        check("post-arst miso", r, 8'hFF);
        check("post-arst underruns", und_cnt - u0, 1);
        check("post-arst rx pulses frame", rx_cnt - rx0, 1);
        check("post-arst rx_data", rx_data, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
